skinny_inv_sbox8_pini1_hs: RTL and testbench
============================================

# skinny_inv_sbox8_pini1_hs

Masked inverse of the SKINNY-128 8-bit S-box (S8⁻¹) for the first-order PINI datapath, with a valid/ready wrapper. It accepts two Boolean shares plus 8 fresh random bits, holds them stable internally for the full evaluation, and returns two output shares whose XOR equals S8⁻¹ of the unmasked input. The block sits in the decryption-side round function, next to the forward masked S-box. It removes the hold-inputs-for-4-cycles burden from the round controller.

## Interface
- SHARES, 2, number of Boolean shares; fixed, not overridable.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  si1/si0/r are valid.
- in_ready  out  1  block can accept; combinational: (state==IDLE) | (state==DONE & out_ready).
- si1  in  8  input share 1.
- si0  in  8  input share 0.
- r  in  8  fresh randomness; one bit per gadget; must be fresh per accepted transfer.
- out_valid  out  1  so1/so0 hold a result.
- out_ready  in  1  consumer accepts the result.
- so1  out  8  output share 1; registered.
- so0  out  8  output share 0; registered.
- busy  out  1  state is EVAL or CAPT.

## Operation
- Accept occurs on a rising edge with in_valid & in_ready (edge E0). At E0, si1, si0 and r are captured into holding registers. The holding registers do not change again until the next accept.
- The datapath uses eight PINI1 NOR-XOR gadgets. Each gadget computes f = NOR(a,b) ^ z share-wise, has one register stage, and consumes one r bit. Inputs are o = si and b = result.
- Layer 1:
  - b2 = o0 ^ NOR(o3,o1), uses r[0].
  - b3 = o4 ^ NOR(o7,o6), uses r[1].
  - b7 = o1 ^ NOR(o2,o7), uses r[2].
  - b5 = o7 ^ NOR(o6,o5), uses r[3].
- Layer 2:
  - b1 = o3 ^ NOR(o5,b3), uses r[4].
  - b0 = o5 ^ NOR(b3,b2), uses r[5].
- Layer 3: b6 = o2 ^ NOR(b2,b1), uses r[6].
- Layer 4: b4 = o6 ^ NOR(b7,b6), uses r[7].
- Shares are never combined. No signal may depend on both si1 and si0 except through gadget registers.
- FSM states and transitions:
  - IDLE → EVAL on accept; cnt←0.
  - EVAL: cnt increments on each edge. When cnt==3, the next edge goes to CAPT.
  - CAPT: on the next edge, load so1/so0 from layer outputs and go to DONE.
  - DONE: out_valid=1. If out_ready & in_valid, go to EVAL and treat this edge as a new E0. If out_ready only, go to IDLE. Otherwise hold.
- When out_valid & !out_ready, so1/so0 stay stable. They change only at CAPT→DONE.

## Timing
- Latency: out_valid rises after edge E5 (5 edges after accept).
- Throughput: one S-box per 6 edges when back-to-back.
- Reset values: state=IDLE, cnt=0, out_valid=0, busy=0, so1=so0=8'h00.
- Holding and gadget registers are also cleared on reset.
- in_ready=0 during a cycle with rst=1.
- Reset mid-operation (EVAL, CAPT or DONE): the transfer is aborted, no output is produced, and the result is discarded.
- in_valid is ignored while in EVAL or CAPT. Upstream must hold it until in_ready.
- Simultaneous out_ready & in_valid in DONE: both handshakes complete on the same edge. out_valid drops for exactly 5 edges.

## Structure
- The package skinny_pini_pkg holds:
  - INV_SBOX_LAT=4, NSHARES=2, RBITS=8;
  - the FSM state enum {IDLE, EVAL, CAPT, DONE};
  - the 2-bit cnt width.
- Sub-module skinny_inv_sbox8_pini1_core holds the 8-gadget datapath. It reuses the existing gadget pini1_sbox8_cfn_fr with r bits assigned as above.
- The top level holds the FSM, the holding registers and the output registers.
- All share registers carry equivalent_register_removal="no".

## Test plan
- Reset for 3 cycles, then release. Required: out_valid=0, so1=so0=0, in_ready=1 on the first cycle after release.
- si1=0xA5, si0=0xC0 (unmasked 0x65), random r. Required: out_valid after E5, and so1^so0=0x00.
- Unmasked 0x4C → 0x01; 0xFF → 0xFF.
- Exhaustive sweep of all 256 inputs, 4 random mask/r sets each. Required: so1^so0 matches the S8⁻¹ table every time.
- Hold out_ready=0 for 10 cycles after out_valid. Required: so1/so0/out_valid stable, in_ready=0. Then pulse out_ready with in_valid=1. Required: back-to-back accept, next out_valid 6 edges after the previous one.
- Assert rst at EVAL cnt=2, with si and r changed after accept. Required: no out_valid, IDLE after release, and the next transfer produces the correct result.

Source files
------------

// File: rtl/skinny_inv_sbox8_pini1_hs_pkg.sv
// skinny_pini_pkg: shared constants, counter type and FSM state type for the masked inverse S-box
// No ports; imported by the interface, the datapath core and the top level.
package skinny_pini_pkg;
    localparam int INV_SBOX_LAT = 4;
    localparam int NSHARES = 2;
    localparam int RBITS = 8;
    localparam int CNT_W = 2;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, EVAL, CAPT, DONE} state_t;
endpackage

// File: rtl/skinny_inv_sbox8_pini1_hs_if.sv
// skinny_inv_sbox8_pini1_hs_if: valid/ready bus of the masked inverse S-box
// Signals:
//   in_valid/in_ready   input handshake for si1, si0 (shares) and r (fresh randomness)
//   out_valid/out_ready output handshake for so1, so0 (shares)
//   busy                evaluation in progress
// master = producer/consumer side, slave = S-box side.
interface skinny_inv_sbox8_pini1_hs_if;
    import skinny_pini_pkg::*;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       si1;
    logic [7:0]       si0;
    logic [RBITS-1:0] r;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       so1;
    logic [7:0]       so0;
    logic             busy;
    modport master (
        output in_valid, si1, si0, r, out_ready,
        input  in_ready, out_valid, so1, so0, busy
    );
    modport slave (
        input  in_valid, si1, si0, r, out_ready,
        output in_ready, out_valid, so1, so0, busy
    );
endinterface

// File: rtl/skinny_inv_sbox8_pini1_hs_core.sv
// pini1_sbox8_cfn_fr: first-order PINI gadget f = NOR(a,b) ^ z on two shares, one register stage
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all registers)
//   i_a1/i_a0, i_b1/i_b0, i_z1/i_z0  shares of a, b, z
//   i_r                 one fresh random bit
//   o_f1/o_f0           shares of f, valid one edge after the inputs
module pini1_sbox8_cfn_fr (
    input  logic clk,
    input  logic rst,
    input  logic i_a1,
    input  logic i_a0,
    input  logic i_b1,
    input  logic i_b0,
    input  logic i_z1,
    input  logic i_z0,
    input  logic i_r,
    output logic o_f1,
    output logic o_f0
);
    // NOR(a,b) = A & B with A = ~a, B = ~b; complementing share 0 complements the value.
    // The AND is an HPC2 multiplication: cross-share terms only meet after registers.
    logic w_na0;
    logic w_nb0;
    (* equivalent_register_removal = "no" *) logic r_p1, r_p0;
    (* equivalent_register_removal = "no" *) logic r_q1, r_q0;
    (* equivalent_register_removal = "no" *) logic r_m1, r_m0;
    (* equivalent_register_removal = "no" *) logic r_x1, r_x0;
    (* equivalent_register_removal = "no" *) logic r_z1, r_z0;
    assign w_na0 = ~i_a0;
    assign w_nb0 = ~i_b0;
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_p1, r_p0, r_q1, r_q0, r_m1, r_m0, r_x1, r_x0, r_z1, r_z0} <= '0;
        end else begin
            r_p0 <= w_na0 & w_nb0;
            r_p1 <= i_a1 & i_b1;
            r_q0 <= i_a0 & i_r;
            r_q1 <= ~i_a1 & i_r;
            r_m0 <= w_na0;
            r_m1 <= i_a1;
            r_x0 <= i_b1 ^ i_r;
            r_x1 <= w_nb0 ^ i_r;
            r_z0 <= i_z0;
            r_z1 <= i_z1;
        end
    end
    assign o_f0 = r_p0 ^ r_q0 ^ (r_m0 & r_x0) ^ r_z0;
    assign o_f1 = r_p1 ^ r_q1 ^ (r_m1 & r_x1) ^ r_z1;
endmodule

// skinny_inv_sbox8_pini1_core: 8-gadget masked S8 inverse network, four gadget layers deep
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_o1/i_o0           input shares, must stay stable during evaluation
//   i_r                 one fresh bit per gadget
//   o_b1/o_b0           result shares, valid four edges after the inputs settle
module skinny_inv_sbox8_pini1_core
    import skinny_pini_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_o1,
    input  logic [7:0]       i_o0,
    input  logic [RBITS-1:0] i_r,
    output logic [7:0]       o_b1,
    output logic [7:0]       o_b0
);
    // Gadget g produces result bit b[g]. Operand index 0..7 selects o, 8..15 selects b.
    localparam int SA [8] = '{11, 5, 3, 7, 15, 6, 10, 2};
    localparam int SB [8] = '{10, 11, 1, 6, 14, 5, 9, 7};
    localparam int SZ [8] = '{5, 3, 0, 4, 6, 7, 2, 1};
    localparam int RI [8] = '{5, 4, 0, 1, 7, 3, 6, 2};
    logic [15:0] w_v1;
    logic [15:0] w_v0;
    assign w_v1 = {o_b1, i_o1};
    assign w_v0 = {o_b0, i_o0};
    for (genvar g = 0; g < 8; g++) begin : g_gadget
        pini1_sbox8_cfn_fr u_gadget (
            .clk  (clk),
            .rst  (rst),
            .i_a1 (w_v1[SA[g]]),
            .i_a0 (w_v0[SA[g]]),
            .i_b1 (w_v1[SB[g]]),
            .i_b0 (w_v0[SB[g]]),
            .i_z1 (w_v1[SZ[g]]),
            .i_z0 (w_v0[SZ[g]]),
            .i_r  (i_r[RI[g]]),
            .o_f1 (o_b1[g]),
            .o_f0 (o_b0[g])
        );
    end
endmodule

// File: rtl/skinny_inv_sbox8_pini1_hs.sv
// skinny_inv_sbox8_pini1_hs: masked SKINNY-128 inverse S-box with valid/ready handshake
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any transfer in flight
//   bus   slave side of skinny_inv_sbox8_pini1_hs_if (input shares + randomness in,
//         output shares out, busy while evaluating)
module skinny_inv_sbox8_pini1_hs
    import skinny_pini_pkg::*;
(
    input logic                         clk,
    input logic                         rst,
    skinny_inv_sbox8_pini1_hs_if.slave  bus
);
    localparam cnt_t CNT_LAST = cnt_t'(INV_SBOX_LAT - 1);
    state_t r_state;
    state_t w_state_nx;
    cnt_t   r_cnt;
    cnt_t   w_cnt_nx;
    logic   w_acc;
    logic   w_ld;
    logic [7:0] w_b1;
    logic [7:0] w_b0;
    (* equivalent_register_removal = "no" *) logic [NSHARES-1:0][7:0] r_hold;
    (* equivalent_register_removal = "no" *) logic [RBITS-1:0] r_rnd;
    (* equivalent_register_removal = "no" *) logic [7:0] r_so1;
    (* equivalent_register_removal = "no" *) logic [7:0] r_so0;
    assign bus.in_ready  = !rst && (r_state == IDLE || (r_state == DONE && bus.out_ready));
    assign bus.out_valid = r_state == DONE;
    assign bus.busy      = r_state == EVAL || r_state == CAPT;
    assign bus.so1       = r_so1;
    assign bus.so0       = r_so0;
    assign w_acc         = bus.in_valid && bus.in_ready;
    // Holding registers keep the gadget inputs stable for the whole evaluation.
    skinny_inv_sbox8_pini1_core u_core (
        .clk  (clk),
        .rst  (rst),
        .i_o1 (r_hold[1]),
        .i_o0 (r_hold[0]),
        .i_r  (r_rnd),
        .o_b1 (w_b1),
        .o_b0 (w_b0)
    );
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ld       = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nx = w_acc ? EVAL : IDLE;
                w_cnt_nx   = '0;
            end
            EVAL: begin
                w_state_nx = r_cnt == CNT_LAST ? CAPT : EVAL;
                w_cnt_nx   = r_cnt + 1'b1;
            end
            CAPT: begin
                w_state_nx = DONE;
                w_ld       = 1'b1;
            end
            DONE: begin
                w_state_nx = bus.out_ready ? (bus.in_valid ? EVAL : IDLE) : DONE;
                w_cnt_nx   = '0;
            end
            default: w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_rnd   <= '0;
            r_so1   <= '0;
            r_so0   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_acc) begin
                r_hold <= {bus.si1, bus.si0};
                r_rnd  <= bus.r;
            end
            if (w_ld) begin
                r_so1 <= w_b1;
                r_so0 <= w_b0;
            end
        end
    end
endmodule

// File: tb/tb_skinny_inv_sbox8_pini1_hs.sv
// tb_skinny_inv_sbox8_pini1_hs: scoreboard bench for the masked inverse S-box
module tb_skinny_inv_sbox8_pini1_hs;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sb [$];
    logic [7:0] inv_tbl [256];

    skinny_inv_sbox8_pini1_hs_if bus ();
    skinny_inv_sbox8_pini1_hs dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Unmasked S8 inverse straight from the bit-level layer rules.
    function automatic logic [7:0] inv_ref(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        b[2] = x[0] ^ ~(x[3] | x[1]);
        b[3] = x[4] ^ ~(x[7] | x[6]);
        b[7] = x[1] ^ ~(x[2] | x[7]);
        b[5] = x[7] ^ ~(x[6] | x[5]);
        b[1] = x[3] ^ ~(x[5] | b[3]);
        b[0] = x[5] ^ ~(b[3] | b[2]);
        b[6] = x[2] ^ ~(b[2] | b[1]);
        b[4] = x[6] ^ ~(b[7] | b[6]);
        return b;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_raw(input logic [7:0] s1, input logic [7:0] s0, input logic [7:0] exp);
        int n = 0;
        bus.si1 = s1;
        bus.si0 = s0;
        bus.r = 8'($urandom);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) sb.push_back(exp);
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, want high", n);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.si1 = 8'($urandom);
        bus.si0 = 8'($urandom);
        bus.r = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] exp);
        logic [7:0] m;
        m = 8'($urandom);
        send_raw(m, m ^ x, exp);
    endtask

    task automatic present(input logic [7:0] x);
        logic [7:0] m;
        m = 8'($urandom);
        bus.si1 = m;
        bus.si0 = m ^ x;
        bus.r = 8'($urandom);
        bus.in_valid = 1'b1;
    endtask

    // Counts rising edges until out_valid is seen high (bounded at 20).
    task automatic edges_to_valid(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed output handshake is checked against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h, want no output", bus.so1 ^ bus.so0);
                end else begin
                    e = sb.pop_front();
                    chk("sbox_out", int'(bus.so1 ^ bus.so0), int'(e));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] s1, s0, x, y;
        for (int i = 0; i < 256; i++) inv_tbl[i] = inv_ref(8'(i));
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.si1 = 8'h00;
        bus.si0 = 8'h00;
        bus.r = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_rst", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_so1", int'(bus.so1), 0);
        chk("rst_so0", int'(bus.so0), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        send_raw(8'hA5, 8'hC0, 8'h00);
        @(negedge clk);
        chk("busy_eval", int'(bus.busy), 1);
        chk("in_ready_eval", int'(bus.in_ready), 0);
        edges_to_valid(n);
        chk("latency", n, 5);
        @(posedge clk);
        #1;
        send(8'h4C, 8'h01);
        send(8'hFF, 8'hFF);
        drain();

        for (int v = 0; v < 256; v++) begin
            for (int k = 0; k < 4; k++) begin
                send(8'(v), inv_tbl[v]);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();

        bus.out_ready = 1'b0;
        x = 8'($urandom);
        send(x, inv_tbl[x]);
        edges_to_valid(n);
        chk("latency_bp", n, 5);
        s1 = bus.so1;
        s0 = bus.so0;
        chk("bp_value", int'(s1 ^ s0), int'(inv_tbl[x]));
        @(posedge clk);
        #1;
        x = 8'($urandom);
        present(x);
        repeat (10) begin
            @(negedge clk);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_so1_stable", int'(bus.so1), int'(s1));
            chk("bp_so0_stable", int'(bus.so0), int'(s0));
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", int'(bus.in_ready), 1);
        sb.push_back(inv_tbl[x]);
        @(posedge clk);
        #1;
        y = 8'($urandom);
        present(y);
        edges_to_valid(n);
        chk("latency_b2b", n, 5);
        chk("b2b_in_ready2", int'(bus.in_ready), 1);
        sb.push_back(inv_tbl[y]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edges_to_valid(n);
        chk("rise_to_rise", n + 1, 6);
        @(posedge clk);
        #1;
        drain();

        send(8'h9A, inv_tbl[8'h9A]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_in_ready_rst", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", int'(bus.busy), 0);
        chk("abort_idle_in_ready", int'(bus.in_ready), 1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("abort_no_output", n, 0);
        @(posedge clk);
        #1;
        send(8'h9A, inv_tbl[8'h9A]);
        send(8'h4C, 8'h01);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
